// File: rtl/jpeg_block_sequencer_if.sv
// Bundle of sequencer control, pixel-memory and encoder signals; master = sequencer side.
// The slave modport is the view taken by the memory, the encoder and the frame controller.
interface jpeg_block_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int BLK_W  = 6
);
   logic              frame_start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic [BLK_W-1:0]  img_w_blk;
   logic [BLK_W-1:0]  img_h_blk;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rd_data;
   logic              enc_start;
   logic [7:0]        enc_pixel;
   logic              enc_done;
   logic              busy;
   logic [BLK_W-1:0]  blk_x;
   logic [BLK_W-1:0]  blk_y;
   logic              frame_done;
   logic              err;

   modport master (
      input  frame_start, abort, base_addr, img_w_blk, img_h_blk, mem_rd_data, enc_done,
      output mem_rd_en, mem_addr, enc_start, enc_pixel, busy, blk_x, blk_y, frame_done, err
   );

   modport slave (
      output frame_start, abort, base_addr, img_w_blk, img_h_blk, mem_rd_data, enc_done,
      input  mem_rd_en, mem_addr, enc_start, enc_pixel, busy, blk_x, blk_y, frame_done, err
   );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// Walks a raster image in 8x8 blocks, feeding one pixel per cycle to the block encoder.
// Block period is 66 cycles plus encoder wait; abort returns to IDLE on the next edge.
module jpeg_block_sequencer #(
   parameter int ADDR_W  = 16,
   parameter int BLK_W   = 6,
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   jpeg_block_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, START, FEED, WAIT_DONE, NEXT} state_t;

   state_t            state;
   logic [BLK_W-1:0]  w_blk, h_blk, bx, by;
   logic [ADDR_W-1:0] stride, row_base, blk_base, row_ptr, addr_q;
   logic [5:0]        pix_cnt;
   logic [15:0]       wait_cnt;
   logic              rd_en_q, start_q, busy_q, done_q, err_q;

   logic [2:0]        nxt_col;
   logic [ADDR_W-1:0] nxt_addr, nxt_row_base, nxt_blk_base;
   logic              last_col, last_row;

   // Next pixel address: step by one within a row, or jump one image row from the row pointer.
   always_comb begin
      nxt_col      = (state == START) ? 3'd1 : pix_cnt[2:0] + 3'd2;
      nxt_addr     = (nxt_col == 3'd0) ? row_ptr + stride : addr_q + ADDR_W'(1);
      last_col     = (bx == w_blk - BLK_W'(1));
      last_row     = (by == h_blk - BLK_W'(1));
      nxt_row_base = row_base + (stride << 3);
      nxt_blk_base = last_col ? nxt_row_base : blk_base + ADDR_W'(8);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         w_blk    <= '0;
         h_blk    <= '0;
         bx       <= '0;
         by       <= '0;
         stride   <= '0;
         row_base <= '0;
         blk_base <= '0;
         row_ptr  <= '0;
         addr_q   <= '0;
         pix_cnt  <= '0;
         wait_cnt <= '0;
         rd_en_q  <= 1'b0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         if (bus.abort) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.frame_start) begin
                     w_blk    <= bus.img_w_blk;
                     h_blk    <= bus.img_h_blk;
                     stride   <= ADDR_W'({bus.img_w_blk, 3'b000});
                     row_base <= bus.base_addr;
                     blk_base <= bus.base_addr;
                     row_ptr  <= bus.base_addr;
                     addr_q   <= bus.base_addr;
                     bx       <= '0;
                     by       <= '0;
                     if (bus.img_w_blk == '0 || bus.img_h_blk == '0) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                     end else begin
                        err_q   <= 1'b0;
                        state   <= START;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        rd_en_q <= 1'b1;
                     end
                  end
               end
               START: begin
                  state   <= FEED;
                  pix_cnt <= '0;
                  addr_q  <= nxt_addr;
               end
               FEED: begin
                  pix_cnt <= pix_cnt + 6'd1;
                  rd_en_q <= (pix_cnt < 6'd62);
                  if (pix_cnt < 6'd62) begin
                     addr_q <= nxt_addr;
                     if (nxt_col == 3'd0) row_ptr <= nxt_addr;
                  end
                  if (pix_cnt == 6'd63) begin
                     wait_cnt <= '0;
                     state    <= bus.enc_done ? NEXT : WAIT_DONE;
                  end
               end
               WAIT_DONE: begin
                  if (bus.enc_done) begin
                     state <= NEXT;
                  end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                     err_q  <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     wait_cnt <= wait_cnt + 16'd1;
                  end
               end
               NEXT: begin
                  if (last_col && last_row) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     if (last_col) begin
                        bx       <= '0;
                        by       <= by + BLK_W'(1);
                        row_base <= nxt_row_base;
                     end else begin
                        bx <= bx + BLK_W'(1);
                     end
                     blk_base <= nxt_blk_base;
                     row_ptr  <= nxt_blk_base;
                     addr_q   <= nxt_blk_base;
                     start_q  <= 1'b1;
                     rd_en_q  <= 1'b1;
                     state    <= START;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.mem_rd_en  = rd_en_q;
   assign bus.mem_addr   = addr_q;
   assign bus.enc_start  = start_q;
   assign bus.enc_pixel  = (state == FEED) ? bus.mem_rd_data : 8'd0;
   assign bus.busy       = busy_q;
   assign bus.blk_x      = bx;
   assign bus.blk_y      = by;
   assign bus.frame_done = done_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Scoreboard bench: expected reads, pixels, block order and frame_done results are queued at stimulus time.
module tb_jpeg_block_sequencer;
   localparam int ADDR_W  = 16;
   localparam int BLK_W   = 6;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [BLK_W-1:0] x;
      logic [BLK_W-1:0] y;
   } blk_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jpeg_block_sequencer_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) bus();
   jpeg_block_sequencer #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [0:65535];
   always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

   blk_t        exp_blk[$];
   logic [15:0] exp_addr[$];
   logic [7:0]  exp_pix[$];
   logic        exp_fd[$];

   // enc_mode: -1 random done delay 0..14, -2 never done, >=0 fixed delay
   int enc_mode = -1;
   int pix_left = 0, dly = -1, cur_n = 0, prev_start = 0, prev_n = 0, fd_cnt = 0;
   bit have_prev = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor plus behavioural encoder: done N cycles after the 64th pixel.
   always @(negedge clk) begin
      bus.enc_done = 1'b0;
      if (rst_n) begin
         if (bus.mem_rd_en) begin
            check("read_expected", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) check("mem_addr", bus.mem_addr, exp_addr.pop_front());
         end
         if (bus.enc_start) begin
            check("start_expected", 32'(exp_blk.size() != 0), 1);
            if (exp_blk.size() != 0) begin
               blk_t b;
               b = exp_blk.pop_front();
               check("blk_x", bus.blk_x, b.x);
               check("blk_y", bus.blk_y, b.y);
            end
            if (have_prev) check("block_period", cyc - prev_start, 66 + prev_n);
            cur_n = (enc_mode == -1) ? int'($urandom_range(0, 14)) : ((enc_mode < 0) ? 0 : enc_mode);
            prev_start = cyc;
            prev_n = cur_n;
            have_prev = 1;
            pix_left = 64;
            dly = -1;
         end else if (pix_left > 0) begin
            check("pixel_expected", 32'(exp_pix.size() != 0), 1);
            if (exp_pix.size() != 0) check("enc_pixel", bus.enc_pixel, exp_pix.pop_front());
            pix_left--;
            if (pix_left == 0 && enc_mode != -2) dly = cur_n;
         end else if (dly > 0) begin
            dly--;
         end
         if (dly == 0) begin
            bus.enc_done = 1'b1;
            dly = -1;
         end
         if (bus.frame_done) begin
            fd_cnt++;
            check("frame_done_expected", 32'(exp_fd.size() != 0), 1);
            if (exp_fd.size() != 0) check("err_at_frame_done", bus.err, exp_fd.pop_front());
            check("busy_at_frame_done", bus.busy, 0);
            if (have_prev) check("frame_done_timing", cyc - prev_start, 66 + prev_n);
            have_prev = 0;
         end
      end
   end

   task automatic flush();
      exp_blk.delete();
      exp_addr.delete();
      exp_pix.delete();
      exp_fd.delete();
      pix_left = 0;
      dly = -1;
      have_prev = 0;
   endtask

   // Reference: pixel (r,c) of block (bx,by) lives at base + (8*by+r)*8*w + 8*bx + c.
   task automatic push_frame(input logic [15:0] base, input int w, input int h, input bit want_fd);
      for (int by = 0; by < h; by++) begin
         for (int bx = 0; bx < w; bx++) begin
            blk_t b;
            b.x = BLK_W'(bx);
            b.y = BLK_W'(by);
            exp_blk.push_back(b);
            for (int p = 0; p < 64; p++) begin
               logic [15:0] a;
               a = base + 16'((by * 8 + p / 8) * 8 * w + bx * 8 + p % 8);
               exp_addr.push_back(a);
               exp_pix.push_back(mem[a]);
            end
         end
      end
      if (want_fd) exp_fd.push_back(1'b0);
   endtask

   task automatic pulse_start(input logic [15:0] base, input int w, input int h);
      @(negedge clk);
      bus.base_addr = base;
      bus.img_w_blk = BLK_W'(w);
      bus.img_h_blk = BLK_W'(h);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   task automatic finish_frame(input int tgt, input string name);
      int n = 0;
      while (fd_cnt < tgt && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_frame_done_seen"}, 32'(fd_cnt >= tgt), 1);
      repeat (3) @(negedge clk);
      check({name, "_one_frame_done"}, fd_cnt, tgt);
      check({name, "_reads_drained"}, exp_addr.size(), 0);
      check({name, "_pixels_drained"}, exp_pix.size(), 0);
      check({name, "_blocks_drained"}, exp_blk.size(), 0);
      check({name, "_err"}, bus.err, 0);
      check({name, "_busy"}, bus.busy, 0);
   endtask

   task automatic run_frame(input logic [15:0] base, input int w, input int h, input int mode, input string name);
      int tgt;
      flush();
      enc_mode = mode;
      tgt = fd_cnt + 1;
      push_frame(base, w, h, 1'b1);
      pulse_start(base, w, h);
      finish_frame(tgt, name);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_busy"}, bus.busy, 0);
      check({name, "_mem_rd_en"}, bus.mem_rd_en, 0);
      check({name, "_mem_addr"}, bus.mem_addr, 0);
      check({name, "_enc_start"}, bus.enc_start, 0);
      check({name, "_enc_pixel"}, bus.enc_pixel, 0);
      check({name, "_blk_x"}, bus.blk_x, 0);
      check({name, "_blk_y"}, bus.blk_y, 0);
      check({name, "_frame_done"}, bus.frame_done, 0);
      check({name, "_err"}, bus.err, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int tgt, n;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      bus.frame_start = 1'b0;
      bus.abort = 1'b0;
      bus.base_addr = '0;
      bus.img_w_blk = '0;
      bus.img_h_blk = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      run_frame(16'h0100, 1, 1, 5, "t1");

      // 3x2 frame with a frame_start during the frame that must be dropped
      flush();
      enc_mode = -1;
      tgt = fd_cnt + 1;
      push_frame(16'h0000, 3, 2, 1'b1);
      pulse_start(16'h0000, 3, 2);
      repeat (100) @(negedge clk);
      pulse_start(16'h5555, 1, 1);
      finish_frame(tgt, "t2");

      run_frame(16'hFFF0, 2, 1, -1, "wrap");
      for (int i = 0; i < 3; i++)
         run_frame(16'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), -1, "rand");

      // Encoder never answers: timeout after TIMEOUT cycles in WAIT_DONE
      flush();
      enc_mode = -2;
      tgt = fd_cnt;
      push_frame(16'h0300, 1, 1, 1'b0);
      pulse_start(16'h0300, 1, 1);
      n = 0;
      while (!bus.err && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("timeout_err", bus.err, 1);
      check("timeout_latency", cyc - prev_start, 65 + TIMEOUT);
      check("timeout_busy", bus.busy, 0);
      repeat (5) @(negedge clk);
      check("timeout_no_frame_done", fd_cnt, tgt);
      check("timeout_reads_drained", exp_addr.size(), 0);

      // Abort at FEED k=30
      flush();
      enc_mode = -1;
      tgt = fd_cnt;
      push_frame(16'h2000, 2, 2, 1'b0);
      pulse_start(16'h2000, 2, 2);
      check("abort_start_seen", bus.enc_start, 1);
      repeat (31) @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      flush();
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_mem_rd_en", bus.mem_rd_en, 0);
      check("abort_enc_start", bus.enc_start, 0);
      check("abort_enc_pixel", bus.enc_pixel, 0);
      check("abort_err", bus.err, 0);
      // abort together with frame_start in IDLE: abort wins
      bus.abort = 1'b1;
      pulse_start(16'h2000, 1, 1);
      bus.abort = 1'b0;
      check("abort_wins_busy", bus.busy, 0);
      check("abort_wins_enc_start", bus.enc_start, 0);
      repeat (3) @(negedge clk);
      check("abort_no_frame_done", fd_cnt, tgt);
      run_frame(16'h2000, 2, 1, -1, "after_abort");

      // Zero-sized image in either dimension
      for (int i = 0; i < 2; i++) begin
         flush();
         tgt = fd_cnt + 1;
         exp_fd.push_back(1'b1);
         pulse_start(16'h1234, (i == 0) ? 0 : 3, (i == 0) ? 2 : 0);
         repeat (3) @(negedge clk);
         check("zero_dim_err", bus.err, 1);
         check("zero_dim_busy", bus.busy, 0);
         check("zero_dim_frame_done_count", fd_cnt, tgt);
      end
      run_frame(16'h0040, 1, 2, -1, "err_cleared");

      // Asynchronous reset while waiting for the encoder
      flush();
      enc_mode = -2;
      push_frame(16'h0400, 2, 1, 1'b0);
      pulse_start(16'h0400, 2, 1);
      repeat (70) @(negedge clk);
      check("pre_reset_busy", bus.busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      flush();
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(16'h0800, 2, 2, -1, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
